// File: rtl/fft_stage1_sequencer.sv
// ---------------------------------------------------------------------------
// fft_stage1_sequencer
//
// Frame-level valid/ready controller for the first radix stage of the FFT
// pipeline (butterfly10 -> butterfly11 -> butterfly12 -> cbfp_stage1).
// Sample data never passes through here; this block only decides when an
// upstream beat may enter the stage, groups beats into frames, limits the
// number of beats outstanding against the downstream buffer (credits), and
// tags beats coming back out of the stage with start/end-of-frame markers.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   start           pulse, arms sequencing (only honoured in IDLE)
//   stop            pulse, halt at the next frame boundary
//   s_valid         upstream beat available
//   s_ready         beat accepted this cycle when s_valid & s_ready
//   pipe_valid_in   stage valid_in (= s_valid & s_ready)
//   pipe_valid_out  stage valid_out, one per returning beat
//   credit_return   downstream freed one beat slot
//   m_sof / m_eof   returning beat is first / last of a frame
//   busy            sequencer not idle
//   done            one-cycle pulse when draining completes
//   frames_out      completed output frames, wraps at 2^16
//   err             sticky protocol-violation flag
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start, no beats accepted
// ST_RUN   | accepting beats while credits remain
// ST_DRAIN | frame boundary reached after stop; wait for stage to empty
// ---------------------------------------------------------------------------
module fft_stage1_sequencer #(
  parameter int BEATS_PER_FRAME = 32,
  parameter int CREDITS         = 64,
  parameter int CNT_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        pipe_valid_in,
  input  logic        pipe_valid_out,
  input  logic        credit_return,
  output logic        m_sof,
  output logic        m_eof,
  output logic        busy,
  output logic        done,
  output logic [15:0] frames_out,
  output logic        err
);

  localparam int BEAT_W = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS_PER_FRAME - 1);
  localparam logic [CNT_W-1:0]  CREDITS_MAX = CNT_W'(CREDITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              stop_pend_q, stop_pend_d;
  logic [BEAT_W-1:0] in_beat_q, in_beat_d;
  logic [BEAT_W-1:0] out_beat_q, out_beat_d;
  logic [CNT_W-1:0]  credits_q, credits_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [15:0]       frames_out_q, frames_out_d;
  logic              err_q, err_d;

  logic              issue;
  logic              ret_ok;
  logic              at_frame_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      stop_pend_q  <= 1'b0;
      in_beat_q    <= '0;
      out_beat_q   <= '0;
      credits_q    <= CREDITS_MAX;
      inflight_q   <= '0;
      frames_out_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      stop_pend_q  <= stop_pend_d;
      in_beat_q    <= in_beat_d;
      out_beat_q   <= out_beat_d;
      credits_q    <= credits_d;
      inflight_q   <= inflight_d;
      frames_out_q <= frames_out_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stop_pend_d  = stop_pend_q;
    in_beat_d    = in_beat_q;
    out_beat_d   = out_beat_q;
    credits_d    = credits_q;
    inflight_d   = inflight_q;
    frames_out_d = frames_out_q;
    err_d        = err_q;
    done         = 1'b0;

    busy           = (state_q != ST_IDLE);
    at_frame_start = (in_beat_q == '0);

    // Ready is built from registered state only so it never loops back
    // through s_valid; a pending stop blocks the first beat of a new frame.
    s_ready       = (state_q == ST_RUN) && (credits_q != '0) &&
                    !(stop_pend_q && at_frame_start);
    issue         = s_valid && s_ready;
    pipe_valid_in = issue;

    m_sof = (out_beat_q == '0);
    m_eof = (out_beat_q == LAST_BEAT);

    // A returning beat with nothing in flight is a violation and must not
    // disturb the frame bookkeeping.
    ret_ok = pipe_valid_out && (inflight_q != '0);

    if (issue) begin
      in_beat_d = in_beat_q + BEAT_W'(1);
    end

    if (ret_ok) begin
      out_beat_d = out_beat_q + BEAT_W'(1);
      if (m_eof) begin
        frames_out_d = frames_out_q + 16'd1;
      end
    end

    if (issue && !credit_return) begin
      credits_d = credits_q - CNT_W'(1);
    end else if (credit_return && !issue && (credits_q != CREDITS_MAX)) begin
      credits_d = credits_q + CNT_W'(1);
    end

    if (issue && !pipe_valid_out) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (pipe_valid_out && !issue && (inflight_q != '0)) begin
      inflight_d = inflight_q - CNT_W'(1);
    end

    if ((credit_return && (credits_q == CREDITS_MAX)) ||
        (pipe_valid_out && (inflight_q == '0)) ||
        (start && busy)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        // Leave on the last beat of a frame, or immediately when already
        // sitting on a frame boundary.
        if ((stop_pend_q && ((issue && (in_beat_q == LAST_BEAT)) || at_frame_start)) ||
            (stop && at_frame_start)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((inflight_q == '0) && !pipe_valid_out) begin
          state_d     = ST_IDLE;
          stop_pend_d = 1'b0;
          done        = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign frames_out = frames_out_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fft_stage1_sequencer.sv
module tb_fft_stage1_sequencer;

  localparam int BPF  = 32;
  localparam int CRED = 64;
  localparam int LAT  = 5;

  logic        clk = 1'b0;
  logic        rst, start, stop, s_valid, pipe_valid_out, credit_return;
  logic        s_ready, pipe_valid_in, m_sof, m_eof, busy, done, err;
  logic [15:0] frames_out;

  always #5 clk = ~clk;

  fft_stage1_sequencer #(
    .BEATS_PER_FRAME(BPF),
    .CREDITS        (CRED),
    .CNT_W          (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .pipe_valid_in (pipe_valid_in),
    .pipe_valid_out(pipe_valid_out),
    .credit_return (credit_return),
    .m_sof         (m_sof),
    .m_eof         (m_eof),
    .busy          (busy),
    .done          (done),
    .frames_out    (frames_out),
    .err           (err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] exp_q[$];
  int         issue_cnt, cyc, done_cnt, done_cyc, last_pvo_cyc;
  int         first_cyc, last_cyc;
  logic [LAT-1:0] dly;
  logic       echo, sb_on;

  logic        snap_ready, snap_pvi, snap_pvo, snap_busy, snap_done;
  logic        snap_err, snap_sof, snap_eof;
  logic [15:0] snap_frames;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock cycle: sample outputs mid-cycle, run the scoreboard, then
  // advance the stage model (a fixed LAT-cycle delay line) after the edge.
  task automatic step();
    logic [1:0] e;
    @(negedge clk);
    cyc++;
    snap_ready  = s_ready;
    snap_pvi    = pipe_valid_in;
    snap_pvo    = pipe_valid_out;
    snap_busy   = busy;
    snap_done   = done;
    snap_err    = err;
    snap_sof    = m_sof;
    snap_eof    = m_eof;
    snap_frames = frames_out;
    if (pipe_valid_in) begin
      exp_q.push_back({((issue_cnt % BPF) == 0), ((issue_cnt % BPF) == BPF - 1)});
      issue_cnt++;
    end
    if (pipe_valid_out && sb_on) begin
      last_pvo_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("m_sof", 32'(m_sof), 32'(e[1]));
        check("m_eof", 32'(m_eof), 32'(e[0]));
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (rst) dly = '0;
    else     dly = {dly[LAT-2:0], snap_pvi};
    pipe_valid_out = dly[LAT-1];
    credit_return  = echo & dly[LAT-1];
  endtask

  task automatic clear_sb();
    exp_q.delete();
    issue_cnt    = 0;
    done_cnt     = 0;
    done_cyc     = 0;
    last_pvo_cyc = 0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    s_valid = 1'b0;
    echo    = 1'b0;
    sb_on   = 1'b1;
    step();
    rst = 1'b0;
    clear_sb();
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0;
    pipe_valid_out = 1'b0; credit_return = 1'b0;
    dly = '0; echo = 1'b0; sb_on = 1'b1; cyc = 0;
    clear_sb();
    step();
    step();

    // Reset values, with s_valid high to show nothing gets through
    rst = 1'b0;
    s_valid = 1'b1;
    step();
    check("rst_s_ready", 32'(snap_ready), 32'd0);
    check("rst_pvi", 32'(snap_pvi), 32'd0);
    check("rst_busy", 32'(snap_busy), 32'd0);
    check("rst_done", 32'(snap_done), 32'd0);
    check("rst_sof", 32'(snap_sof), 32'd1);
    check("rst_eof", 32'(snap_eof), 32'd0);
    check("rst_frames", 32'(snap_frames), 32'd0);
    check("rst_err", 32'(snap_err), 32'd0);

    // Two frames back-to-back with credits echoed
    do_reset();
    echo = 1'b1;
    s_valid = 1'b1;
    start_run();
    check("start_busy", 32'(busy), 32'd1);
    first_cyc = -1;
    last_cyc = -1;
    for (int i = 0; i < 200 && issue_cnt < 64; i++) begin
      step();
      if (snap_pvi) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
    s_valid = 1'b0;
    check("t1_issues", 32'(issue_cnt), 32'd64);
    check("t1_consecutive", 32'(last_cyc - first_cyc), 32'd63);
    repeat (10) step();
    check("t1_frames", 32'(snap_frames), 32'd2);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (3) step();
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_idle", 32'(snap_busy), 32'd0);

    // Credit stall: no returns, 64 issues, then a single return
    do_reset();
    s_valid = 1'b1;
    start_run();
    repeat (80) step();
    check("t2_issues", 32'(issue_cnt), 32'd64);
    check("t2_stalled", 32'(snap_ready), 32'd0);
    credit_return = 1'b1;
    step();
    check("t2_ret_cycle", 32'(snap_pvi), 32'd0);
    step();
    check("t2_one_more", 32'(snap_pvi), 32'd1);
    step();
    check("t2_stall_again", 32'(snap_pvi), 32'd0);
    check("t2_issues_final", 32'(issue_cnt), 32'd65);

    // Stop mid-frame at in_beat 10
    do_reset();
    echo = 1'b1;
    s_valid = 1'b1;
    start_run();
    for (int i = 0; i < 100 && issue_cnt < 10; i++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 300 && snap_busy; i++) step();
    check("t3_idle", 32'(snap_busy), 32'd0);
    check("t3_issues", 32'(issue_cnt), 32'd32);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);
    check("t3_frames", 32'(snap_frames), 32'd1);
    check("t3_done_after_last", 32'(done_cyc), 32'(last_pvo_cyc + 1));
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Issue and credit_return together while credits = 1
    do_reset();
    s_valid = 1'b1;
    start_run();
    for (int i = 0; i < 200 && issue_cnt < 63; i++) step();
    for (int i = 0; i < 8; i++) begin
      credit_return = 1'b1;
      step();
      check("t4_hold_ready", 32'(snap_ready), 32'd1);
    end
    step();
    check("t4_last_issue", 32'(snap_pvi), 32'd1);
    step();
    check("t4_stall", 32'(snap_pvi), 32'd0);
    check("t4_issues", 32'(issue_cnt), 32'd72);

    // Violation: pipe_valid_out with nothing in flight
    do_reset();
    start_run();
    step();
    sb_on = 1'b0;
    pipe_valid_out = 1'b1;
    step();
    sb_on = 1'b1;
    step();
    check("v1_err", 32'(snap_err), 32'd1);
    check("v1_sof_kept", 32'(snap_sof), 32'd1);
    check("v1_frames", 32'(snap_frames), 32'd0);

    // Violation: credit_return with credits full; credits must saturate
    do_reset();
    step();
    check("v2_err_clear", 32'(snap_err), 32'd0);
    start_run();
    credit_return = 1'b1;
    step();
    step();
    check("v2_err", 32'(snap_err), 32'd1);
    s_valid = 1'b1;
    repeat (80) step();
    check("v2_issues", 32'(issue_cnt), 32'd64);

    // Violation: start while running; err sticky until rst
    do_reset();
    step();
    check("v3_err_clear", 32'(snap_err), 32'd0);
    start_run();
    start_run();
    step();
    check("v3_err", 32'(snap_err), 32'd1);
    check("v3_busy", 32'(snap_busy), 32'd1);
    repeat (5) step();
    check("v3_err_sticky", 32'(snap_err), 32'd1);
    do_reset();
    step();
    check("v3_err_rst", 32'(snap_err), 32'd0);

    // Reset mid-frame at in_beat 17 with 5 beats in flight
    do_reset();
    echo = 1'b1;
    s_valid = 1'b1;
    start_run();
    for (int i = 0; i < 100 && issue_cnt < 17; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_sb();
    step();
    check("t6_s_ready", 32'(snap_ready), 32'd0);
    check("t6_pvi", 32'(snap_pvi), 32'd0);
    check("t6_busy", 32'(snap_busy), 32'd0);
    check("t6_err", 32'(snap_err), 32'd0);
    check("t6_sof", 32'(snap_sof), 32'd1);
    check("t6_eof", 32'(snap_eof), 32'd0);
    check("t6_frames", 32'(snap_frames), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
